// File: rtl/gc_pkg.sv
// Shared types and constants for the GC compute-datapath sequencer.
package gc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    NORM,
    DONE
  } gc_state_e;

  localparam logic [3:0] N_STEP     = 4'd12;
  localparam logic [3:0] N_HID_STEP = 4'd8;
  localparam logic [3:0] LAST_STEP  = 4'd11;

  typedef struct packed {
    logic [3:0] sel_m;
    logic       sel0;
    logic       sel1;
  } gc_sel_t;

  localparam gc_sel_t SEL_IDLE = '{sel_m: 4'b0000, sel0: 1'b1, sel1: 1'b0};

endpackage

// File: rtl/gc_step_decode.sv
// Step index to row-group / bank / stage select pattern.
module gc_step_decode
  import gc_pkg::*;
(
  input  logic [3:0] step_idx,
  output gc_sel_t    sel
);

  always_comb begin
    sel = SEL_IDLE;
    if (step_idx < N_STEP) begin
      // Output-stage steps 8..11 reuse the low two bits as the row group.
      sel.sel_m                  = '0;
      sel.sel_m[step_idx[1:0]]   = 1'b1;
      sel.sel1                   = (step_idx >= N_HID_STEP);
      sel.sel0                   = (step_idx < N_HID_STEP) ? step_idx[2] : 1'b0;
    end
  end

endmodule

// File: rtl/gc_seq_ctrl.sv
// GC job sequencer: load, settle, 12-step select schedule, normalise, handshake.
module gc_seq_ctrl
  import gc_pkg::*;
#(
  parameter int unsigned DWELL    = 2,
  parameter int unsigned CFG_LAT  = 1,
  parameter int unsigned NORM_LAT = 2,
  parameter int unsigned N_ROW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] sw_in,
  input  logic       dp_stall,
  input  logic       result_ready,
  output logic [2:0] cfg_sel,
  output logic       cfg_load,
  output logic       select_m0,
  output logic       select_m1,
  output logic       select_m2,
  output logic       select_m3,
  output logic       select0,
  output logic       select1,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       norm_en,
  output logic [3:0] step_idx,
  output logic       busy,
  output logic       result_valid
);

  localparam int unsigned DW     = $clog2(DWELL + 1);
  localparam int unsigned LAT_MX = (CFG_LAT > NORM_LAT) ? CFG_LAT : NORM_LAT;
  localparam int unsigned CW     = $clog2(LAT_MX + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] CFG_LAST   = CW'(CFG_LAT - 1);
  localparam logic [CW-1:0] NORM_LAST  = CW'(NORM_LAT - 1);

  gc_state_e        state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;
  logic [2:0]       cfg_sel_q, cfg_sel_d;
  logic [N_ROW-1:0] sel_m_q;
  logic             sel0_q, sel1_q;
  logic             cfg_load_q, acc_clr_q, acc_en_q, norm_en_q, busy_q, valid_q;
  gc_sel_t          dec_sel, sel_d;

  gc_step_decode u_dec (
    .step_idx (step_d),
    .sel      (dec_sel)
  );

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    cfg_sel_d = cfg_sel_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          cfg_sel_d = sw_in;
          step_d    = '0;
        end
      end
      LOAD: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == CFG_LAST) begin
          state_d = RUN;
          step_d  = '0;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!dp_stall) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (step_q == LAST_STEP) begin
              state_d = NORM;
              cnt_d   = '0;
            end else begin
              step_d = step_q + 4'd1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      NORM: begin
        if (!dp_stall) begin
          if (cnt_q == NORM_LAST) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    sel_d = (state_d == RUN) ? dec_sel : SEL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dwell_q    <= '0;
      cnt_q      <= '0;
      step_q     <= '0;
      cfg_sel_q  <= '0;
      sel_m_q    <= '0;
      sel0_q     <= 1'b1;
      sel1_q     <= 1'b0;
      cfg_load_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_en_q   <= 1'b0;
      norm_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      cfg_sel_q  <= cfg_sel_d;
      sel_m_q    <= sel_d.sel_m;
      sel0_q     <= sel_d.sel0;
      sel1_q     <= sel_d.sel1;
      cfg_load_q <= (state_d == LOAD);
      acc_clr_q  <= (state_d == SETTLE) && (state_q == LOAD);
      acc_en_q   <= (state_d == RUN) && (dwell_d == DWELL_LAST);
      norm_en_q  <= (state_d == NORM);
      busy_q     <= (state_d == LOAD) || (state_d == SETTLE) ||
                    (state_d == RUN)  || (state_d == NORM);
      valid_q    <= (state_d == DONE);
    end
  end

  // Strobes stay armed while frozen; the stall only masks them, so a held
  // pulse reappears on the first unstalled cycle.
  assign acc_en       = acc_en_q  & ~dp_stall;
  assign norm_en      = norm_en_q & ~dp_stall;

  assign cfg_sel      = cfg_sel_q;
  assign cfg_load     = cfg_load_q;
  assign select_m0    = sel_m_q[0];
  assign select_m1    = sel_m_q[1];
  assign select_m2    = sel_m_q[2];
  assign select_m3    = sel_m_q[3];
  assign select0      = sel0_q;
  assign select1      = sel1_q;
  assign acc_clr      = acc_clr_q;
  assign step_idx     = step_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_gc_seq_ctrl.sv
// Directed bench for gc_seq_ctrl with default parameters.
module tb_gc_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, dp_stall, result_ready;
  logic [2:0] sw_in, cfg_sel;
  logic       cfg_load, select_m0, select_m1, select_m2, select_m3;
  logic       select0, select1, acc_clr, acc_en, norm_en, busy, result_valid;
  logic [3:0] step_idx;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle trace: ctl = {cfg_load, acc_clr, acc_en, norm_en, result_valid, busy}
  // sel = {select_m3..select_m0, select0, select1}
  logic [5:0] tr_ctl  [64];
  logic [5:0] tr_sel  [64];
  logic [3:0] tr_step [64];
  logic [2:0] tr_cfg  [64];

  gc_seq_ctrl #(.DWELL(2), .CFG_LAT(1), .NORM_LAT(2), .N_ROW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sw_in(sw_in), .dp_stall(dp_stall),
    .result_ready(result_ready), .cfg_sel(cfg_sel), .cfg_load(cfg_load),
    .select_m0(select_m0), .select_m1(select_m1), .select_m2(select_m2),
    .select_m3(select_m3), .select0(select0), .select1(select1),
    .acc_clr(acc_clr), .acc_en(acc_en), .norm_en(norm_en), .step_idx(step_idx),
    .busy(busy), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected select pattern for RUN step s (s < 0 means the idle pattern).
  function automatic logic [5:0] exp_sel(input int s);
    logic [3:0] m;
    if (s < 0) return 6'b0000_1_0;
    if (s < 8) begin
      m = 4'b0001 << (s % 4);
      return {m, (s >= 4), 1'b0};
    end
    m = 4'b0001 << (s - 8);
    return {m, 1'b0, 1'b1};
  endfunction

  function automatic int count_acc(input int ncyc);
    int n = 0;
    for (int c = 0; c < ncyc; c++) if (tr_ctl[c][3]) n++;
    return n;
  endfunction

  // Starts a job at cycle 0 with sw0 and records ncyc cycles of outputs.
  task automatic run_trace(input logic [2:0] sw0, input int ncyc,
                           input int stall_a, input int stall_b,
                           input int start2, input logic [2:0] sw2,
                           input int ready_at, input int reset_at);
    for (int c = 0; c < ncyc; c++) begin
      start        = (c == 0) || (c == start2);
      sw_in        = (c == start2) ? sw2 : sw0;
      dp_stall     = (c >= stall_a) && (c <= stall_b);
      result_ready = (c >= ready_at);
      reset        = (c == reset_at);
      #1;
      tr_ctl[c]  = {cfg_load, acc_clr, acc_en, norm_en, result_valid, busy};
      tr_sel[c]  = {select_m3, select_m2, select_m1, select_m0, select0, select1};
      tr_step[c] = step_idx;
      tr_cfg[c]  = cfg_sel;
      @(posedge clk);
      #1;
    end
    start = 1'b0; dp_stall = 1'b0; result_ready = 1'b0; reset = 1'b0;
  endtask

  task automatic release_done;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; sw_in = '0; dp_stall = 1'b0; result_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({cfg_load, acc_clr, acc_en, norm_en, result_valid, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {cfg_load, acc_clr, acc_en, norm_en, result_valid, busy});
    end
    n_tests++;
    if ({select_m3, select_m2, select_m1, select_m0, select0, select1} !== 6'b000010) begin
      n_fail++;
      $display("FAIL reset_sel got=%b exp=000010",
               {select_m3, select_m2, select_m1, select_m0, select0, select1});
    end
    n_tests++;
    if ({cfg_sel, step_idx} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_cfg_step got=%b/%b exp=000/0000", cfg_sel, step_idx);
    end
  endtask

  task automatic test_nominal;
    logic [5:0] e;
    run_trace(3'b101, 31, -1, -2, -1, 3'b000, 1000, -1);
    for (int c = 0; c < 31; c++) begin
      e = {c == 1, c == 2, (c >= 4 && c <= 26 && c % 2 == 0),
           (c == 27 || c == 28), c >= 29, (c >= 1 && c <= 28)};
      n_tests++;
      if (tr_ctl[c] !== e) begin
        n_fail++;
        $display("FAIL nominal_ctl c=%0d got=%b exp=%b", c, tr_ctl[c], e);
      end
      e = (c >= 3 && c <= 26) ? exp_sel((c - 3) / 2) : exp_sel(-1);
      n_tests++;
      if (tr_sel[c] !== e) begin
        n_fail++;
        $display("FAIL nominal_sel c=%0d got=%b exp=%b", c, tr_sel[c], e);
      end
      if (c >= 3 && c <= 26) begin
        n_tests++;
        if (tr_step[c] !== 4'((c - 3) / 2)) begin
          n_fail++;
          $display("FAIL nominal_step c=%0d got=%0d exp=%0d", c, tr_step[c], (c - 3) / 2);
        end
      end
    end
    n_tests++;
    if (tr_cfg[1] !== 3'd5) begin
      n_fail++;
      $display("FAIL nominal_cfg_sel got=%0d exp=5", tr_cfg[1]);
    end
    n_tests++;
    if (tr_sel[11] !== 6'b0001_1_0 || tr_sel[19] !== 6'b0001_0_1 ||
        tr_sel[25] !== 6'b1000_0_1 || tr_step[26] !== 4'd11) begin
      n_fail++;
      $display("FAIL nominal_checkpoints got=%b/%b/%b/%0d exp=000110/000101/100001/11",
               tr_sel[11], tr_sel[19], tr_sel[25], tr_step[26]);
    end
    n_tests++;
    if (count_acc(31) !== 12) begin
      n_fail++;
      $display("FAIL nominal_acc_count got=%0d exp=12", count_acc(31));
    end
  endtask

  task automatic test_handshake;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({result_valid, busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL hold_valid i=%0d got=%b exp=10", i, {result_valid, busy});
      end
      tick();
    end
    release_done();
    n_tests++;
    if ({result_valid, busy, select_m3, select_m2, select_m1, select_m0, select0, select1}
        !== 8'b00_0000_1_0) begin
      n_fail++;
      $display("FAIL release_idle got=%b exp=00000010",
               {result_valid, busy, select_m3, select_m2, select_m1, select_m0, select0, select1});
    end
  endtask

  task automatic test_stall;
    logic e;
    run_trace(3'b101, 34, 10, 12, -1, 3'b000, 1000, -1);
    for (int c = 0; c < 34; c++) begin
      e = (c >= 4 && c <= 8 && c % 2 == 0) || (c >= 13 && c <= 29 && c % 2 == 1);
      n_tests++;
      if (tr_ctl[c][3] !== e) begin
        n_fail++;
        $display("FAIL stall_acc c=%0d got=%b exp=%b", c, tr_ctl[c][3], e);
      end
      n_tests++;
      if (tr_ctl[c][1] !== (c >= 32)) begin
        n_fail++;
        $display("FAIL stall_valid c=%0d got=%b exp=%b", c, tr_ctl[c][1], c >= 32);
      end
    end
    for (int c = 9; c <= 13; c++) begin
      n_tests++;
      if (tr_sel[c] !== 6'b1000_0_0) begin
        n_fail++;
        $display("FAIL stall_sel_hold c=%0d got=%b exp=100000", c, tr_sel[c]);
      end
    end
    n_tests++;
    if (tr_ctl[30][2] !== 1'b1 || tr_ctl[31][2] !== 1'b1 || count_acc(34) !== 12) begin
      n_fail++;
      $display("FAIL stall_norm_count got=%b%b/%0d exp=11/12",
               tr_ctl[30][2], tr_ctl[31][2], count_acc(34));
    end
    release_done();
  endtask

  task automatic test_start_ignored;
    run_trace(3'b101, 31, -1, -2, 15, 3'b010, 1000, -1);
    for (int c = 1; c < 31; c++) begin
      n_tests++;
      if (tr_ctl[c][5] !== (c == 1) || tr_cfg[c] !== 3'd5) begin
        n_fail++;
        $display("FAIL start_ignored c=%0d got=%b/%0d exp=%b/5",
                 c, tr_ctl[c][5], tr_cfg[c], c == 1);
      end
    end
    n_tests++;
    if (tr_ctl[28][1] !== 1'b0 || tr_ctl[29][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_valid got=%b%b exp=01", tr_ctl[28][1], tr_ctl[29][1]);
    end
    release_done();
  endtask

  task automatic test_reset_midjob;
    run_trace(3'b101, 20, -1, -2, -1, 3'b000, 1000, 18);
    n_tests++;
    if (tr_ctl[17][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midjob_busy_before got=%b exp=1", tr_ctl[17][0]);
    end
    n_tests++;
    if ({tr_ctl[19], tr_sel[19], tr_cfg[19], tr_step[19]} !== {6'b0, 6'b000010, 3'b0, 4'b0}) begin
      n_fail++;
      $display("FAIL midjob_reset got=%b/%b/%0d/%0d exp=000000/000010/0/0",
               tr_ctl[19], tr_sel[19], tr_cfg[19], tr_step[19]);
    end
    run_trace(3'b011, 31, -1, -2, -1, 3'b000, 1000, -1);
    n_tests++;
    if (tr_cfg[1] !== 3'd3 || tr_ctl[28][1] !== 1'b0 || tr_ctl[29][1] !== 1'b1 ||
        count_acc(31) !== 12) begin
      n_fail++;
      $display("FAIL midjob_rerun got=%0d/%b%b/%0d exp=3/01/12",
               tr_cfg[1], tr_ctl[28][1], tr_ctl[29][1], count_acc(31));
    end
    release_done();
  endtask

  task automatic test_back_to_back;
    logic [5:0] g, e;
    run_trace(3'b101, 61, -1, -2, 30, 3'b110, 29, -1);
    for (int c = 0; c < 61; c++) begin
      g = {tr_ctl[c][5], tr_ctl[c][1], tr_ctl[c][0], 3'b0};
      e = {(c == 1 || c == 31), (c == 29 || c == 59),
           ((c >= 1 && c <= 28) || (c >= 31 && c <= 58)), 3'b0};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_ctl c=%0d got=%b exp=%b", c, g[5:3], e[5:3]);
      end
    end
    n_tests++;
    if (tr_cfg[31] !== 3'd6 || count_acc(61) !== 24) begin
      n_fail++;
      $display("FAIL b2b_cfg_acc got=%0d/%0d exp=6/24", tr_cfg[31], count_acc(61));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_handshake();
    test_stall();
    test_start_ignored();
    test_reset_midjob();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
